// File: rtl/fifo_pkg.sv
// Shared defaults and helpers for the single-clock FIFO.
package fifo_pkg;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int DEPTH_DEF      = 8;

  function automatic int addr_w(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// Register-array storage: one synchronous write port, one combinational read address.
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int DEPTH      = DEPTH_DEF,
  parameter int ADDR_W     = addr_w(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     w_addr,
  input  logic [DATA_WIDTH-1:0] w_data,
  input  logic [ADDR_W-1:0]     r_addr,
  output logic [DATA_WIDTH-1:0] r_word
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Contents are never reset; stale entries are unreachable once pointers reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[w_addr] <= w_data;
    end
  end

  assign r_word = mem[r_addr];

endmodule

// File: rtl/fifo.sv
// Single-clock synchronous FIFO with registered read port and counter-derived flags.
module fifo
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int DEPTH      = DEPTH_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  write_enable,
  input  logic                  read_enable,
  input  logic [DATA_WIDTH-1:0] w_data,
  output logic [DATA_WIDTH-1:0] r_data,
  output logic                  full_flag,
  output logic                  empty_flag
);

  localparam int ADDR_W = addr_w(DEPTH);
  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

  logic [ADDR_W-1:0]     wr_ptr;
  logic [ADDR_W-1:0]     rd_ptr;
  logic [ADDR_W:0]       count;
  logic [DATA_WIDTH-1:0] rd_word;
  logic                  wr_acc;
  logic                  rd_acc;

  // Acceptance uses the registered flags, so a simultaneous read+write on
  // empty never bypasses and one on full never overwrites.
  assign wr_acc = write_enable & ~full_flag;
  assign rd_acc = read_enable & ~empty_flag;

  assign full_flag  = (count == FULL_CNT);
  assign empty_flag = (count == '0);

  fifo_mem #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (DEPTH),
    .ADDR_W    (ADDR_W)
  ) u_mem (
    .clk   (clk),
    .we    (wr_acc),
    .w_addr(wr_ptr),
    .w_data(w_data),
    .r_addr(rd_ptr),
    .r_word(rd_word)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      r_data <= '0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_acc) begin
        rd_ptr <= rd_ptr + 1'b1;
        r_data <= rd_word;
      end
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo.sv
// Directed self-checking bench for the single-clock FIFO.
module tb_fifo;

  logic       clk = 1'b0;
  logic       reset;
  logic       write_enable;
  logic       read_enable;
  logic [7:0] w_data;
  logic [7:0] r_data;
  logic       full_flag;
  logic       empty_flag;

  int tests  = 0;
  int failed = 0;

  fifo #(.DATA_WIDTH(8), .DEPTH(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .write_enable(write_enable),
    .read_enable (read_enable),
    .w_data      (w_data),
    .r_data      (r_data),
    .full_flag   (full_flag),
    .empty_flag  (empty_flag)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [7:0] seq1 [8] = '{8'd10, 8'd4, 8'd6, 8'd5, 8'd3, 8'd2, 8'd1, 8'd9};

  initial begin
    reset = 1'b1; write_enable = 1'b0; read_enable = 1'b0; w_data = 8'h00;
    step(); step();
    reset = 1'b0;

    // 1: reset state and read while empty
    check("rst_empty", 32'(empty_flag), 32'd1);
    check("rst_full",  32'(full_flag),  32'd0);
    check("rst_rdata", 32'(r_data),     32'd0);
    read_enable = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      check("rd_empty_rdata", 32'(r_data),     32'd0);
      check("rd_empty_flag",  32'(empty_flag), 32'd1);
    end
    read_enable = 1'b0;

    // 2: fill, overflow attempt, drain
    write_enable = 1'b1;
    for (int i = 0; i < 8; i++) begin
      w_data = seq1[i];
      step();
      check("fill_empty", 32'(empty_flag), 32'd0);
      check("fill_full",  32'(full_flag),  (i == 7) ? 32'd1 : 32'd0);
    end
    w_data = 8'd77;
    step();
    check("ovf_full", 32'(full_flag), 32'd1);
    write_enable = 1'b0;
    read_enable  = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      check("drain_data",  32'(r_data),     32'(seq1[i]));
      check("drain_full",  32'(full_flag),  32'd0);
      check("drain_empty", 32'(empty_flag), (i == 7) ? 32'd1 : 32'd0);
    end
    step();
    check("drain_hold", 32'(r_data), 32'd9);
    read_enable = 1'b0;

    // 3: wrap-around
    write_enable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      w_data = 8'h30 + 8'(i);
      step();
    end
    write_enable = 1'b0;
    read_enable  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("pre_wrap_data", 32'(r_data), 32'h30 + 32'(i));
    end
    check("pre_wrap_empty", 32'(empty_flag), 32'd1);
    read_enable  = 1'b0;
    write_enable = 1'b1;
    for (int i = 0; i < 8; i++) begin
      w_data = 8'h11 + 8'(i);
      step();
      check("wrap_fill_full",  32'(full_flag),  (i == 7) ? 32'd1 : 32'd0);
      check("wrap_fill_empty", 32'(empty_flag), 32'd0);
    end
    write_enable = 1'b0;
    read_enable  = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      check("wrap_data",  32'(r_data),     32'h11 + 32'(i));
      check("wrap_empty", 32'(empty_flag), (i == 7) ? 32'd1 : 32'd0);
    end
    read_enable = 1'b0;

    // 4a: simultaneous read+write with 3 entries
    write_enable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      w_data = 8'h41 + 8'(i);
      step();
    end
    read_enable = 1'b1;
    w_data = 8'h44;
    step();
    check("rw3_data",  32'(r_data),     32'h41);
    check("rw3_empty", 32'(empty_flag), 32'd0);
    write_enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("rw3_drain", 32'(r_data), 32'h42 + 32'(i));
      check("rw3_drain_empty", 32'(empty_flag), (i == 2) ? 32'd1 : 32'd0);
    end

    // 4b: simultaneous read+write when empty
    write_enable = 1'b1;
    w_data = 8'h55;
    step();
    check("rwe_data",  32'(r_data),     32'h44);
    check("rwe_empty", 32'(empty_flag), 32'd0);
    write_enable = 1'b0;
    step();
    check("rwe_read",      32'(r_data),     32'h55);
    check("rwe_read_empty", 32'(empty_flag), 32'd1);
    read_enable = 1'b0;

    // 4c: simultaneous read+write when full
    write_enable = 1'b1;
    for (int i = 0; i < 8; i++) begin
      w_data = 8'h60 + 8'(i);
      step();
    end
    check("rwf_pre_full", 32'(full_flag), 32'd1);
    read_enable = 1'b1;
    w_data = 8'h99;
    step();
    check("rwf_data", 32'(r_data),    32'h60);
    check("rwf_full", 32'(full_flag), 32'd0);
    write_enable = 1'b0;
    for (int i = 0; i < 7; i++) begin
      step();
      check("rwf_drain", 32'(r_data), 32'h61 + 32'(i));
      check("rwf_drain_empty", 32'(empty_flag), (i == 6) ? 32'd1 : 32'd0);
    end
    step();
    check("rwf_hold", 32'(r_data), 32'h67);
    read_enable = 1'b0;

    // 5: reset mid-operation
    write_enable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      w_data = 8'h70 + 8'(i);
      step();
    end
    reset = 1'b1;
    read_enable = 1'b1;
    step();
    reset = 1'b0;
    write_enable = 1'b0;
    read_enable  = 1'b0;
    check("mrst_empty", 32'(empty_flag), 32'd1);
    check("mrst_full",  32'(full_flag),  32'd0);
    check("mrst_rdata", 32'(r_data),     32'd0);
    write_enable = 1'b1;
    w_data = 8'hAA;
    step();
    write_enable = 1'b0;
    read_enable  = 1'b1;
    step();
    read_enable = 1'b0;
    check("mrst_aa",       32'(r_data),     32'hAA);
    check("mrst_aa_empty", 32'(empty_flag), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/fifo.md
Name: fifo

Overview:
Single-clock synchronous FIFO buffering 8-bit data words between a producer and a consumer in the same clock domain. Storage is a register array with wrapping read/write pointers and an occupancy counter. Full and empty status flags are derived from the counter. The read port is registered; there is no combinational read-through.

Parameters:
DATA_WIDTH, 8, width of w_data and r_data in bits.
DEPTH, 8, number of storage entries; must be a power of two and at least 2.
ADDR_W, log2(DEPTH) (3), pointer width; derived, not user-set.

Ports:
clk  input  1  rising-edge clock; all state changes on posedge clk.
reset  input  1  synchronous, active-high reset; sampled on posedge clk.
write_enable  input  1  write request; w_data is captured at the edge if accepted.
read_enable  input  1  read request; the head entry is moved to r_data at the edge if accepted.
w_data  input  DATA_WIDTH  write data.
r_data  output  DATA_WIDTH  registered read data.
full_flag  output  1  high when count == DEPTH.
empty_flag  output  1  high when count == 0.

Behaviour:
- Reset (reset=1 at posedge clk): wr_ptr=0, rd_ptr=0, count=0, r_data=0.
  - Flags after reset: empty_flag=1, full_flag=0.
  - Memory contents are not cleared and are don't-care.
  - Reset has priority over read_enable and write_enable in the same cycle.
  - Reset mid-operation discards all stored data.
- Write acceptance: wr_acc = write_enable & ~full_flag.
  - On wr_acc: mem[wr_ptr] <= w_data; wr_ptr <= wr_ptr+1, wrapping modulo DEPTH.
  - Write while full is ignored silently: no state change, no overwrite.
- Read acceptance: rd_acc = read_enable & ~empty_flag.
  - On rd_acc: r_data <= mem[rd_ptr]; rd_ptr <= rd_ptr+1, wrapping modulo DEPTH.
  - Read latency is 1 cycle: data is valid on r_data after the accepting edge.
  - r_data holds its last value whenever no read is accepted, including a read while empty.
- Count update:
  - +1 on wr_acc only.
  - -1 on rd_acc only.
  - Unchanged when both or neither are accepted.
  - Count width is ADDR_W+1 and never exceeds DEPTH or goes below 0.
- Simultaneous read and write:
  - Each request is evaluated against the flags held before the edge.
  - When empty: the write is accepted and the read is ignored (no bypass). r_data is unchanged; count becomes 1.
  - When full: the read is accepted and the write is rejected. count becomes DEPTH-1.
  - Otherwise both are accepted and count is unchanged.
- Flags are decoded from the registered count. They change only after a clock edge, never combinationally from the enables.
- Ordering is strict FIFO across pointer wrap-around.

Decomposition:
- Package fifo_pkg holds:
  - DATA_WIDTH_DEF = 8 and DEPTH_DEF = 8.
  - A clog2-based ADDR_W helper.
- Sub-module fifo_mem:
  - DEPTH x DATA_WIDTH register array.
  - One synchronous write port and one combinational read address.
  - Instantiated once by fifo.
- Pointer, count and flag logic live in fifo itself.

Test Plan:
1. Reset, then check empty_flag=1, full_flag=0, r_data=0. Hold read_enable=1 for 2 cycles: r_data stays 0 and empty_flag stays 1.
2. Write 10,4,6,5,3,2,1,9 on consecutive cycles. full_flag=1 after the 8th edge and empty_flag=0 after the 1st edge. Write 77 while full: count stays 8 and 77 is never read. Read 8 times: r_data shows 10,4,6,5,3,2,1,9, each one cycle after its read edge. empty_flag=1 after the 8th read.
3. Wrap-around: write 5 words, read 5, then write 8 words 0x11..0x18 so both pointers wrap. Read 8 times: 0x11..0x18 in order. Flags are correct at each step.
4. Simultaneous read+write:
   - With 3 entries: count stays 3 and the oldest word is output.
   - When empty: count becomes 1 and r_data is unchanged.
   - When full: count becomes 7 and the written word is dropped.
5. Reset mid-operation: with 5 entries, assert reset together with read_enable=1 and write_enable=1. Next cycle: empty_flag=1 and r_data=0. A subsequent write of 0xAA followed by a read returns 0xAA.
